// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register with stall/flush/bubble and a circular store-history buffer.
// Define EXE_MEM_FWD_EN for the full SB_DEPTH buffer with forwarding lookup; otherwise a single last-store register.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 4'h0
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 4'h2
`endif

module exe_mem_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_W    = 5,
    parameter int OP_W     = 4,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          sb_clear,
    input  logic                          exe_valid,
    input  logic [DATA_W-1:0]             exe_pc,
    input  logic                          exe_we,
    input  logic [REG_W-1:0]              exe_write_reg,
    input  logic [DATA_W-1:0]             exe_write_data,
    input  logic [OP_W-1:0]               exe_mem_op,
    input  logic [ADDR_W-1:0]             exe_mem_addr,
    input  logic [DATA_W-1:0]             exe_mem_data,
    output logic                          mem_valid,
    output logic [DATA_W-1:0]             mem_pc,
    output logic                          mem_we,
    output logic [REG_W-1:0]              mem_write_reg,
    output logic [DATA_W-1:0]             mem_write_data,
    output logic [OP_W-1:0]               mem_mem_op,
    output logic [ADDR_W-1:0]             mem_mem_addr,
    output logic [DATA_W-1:0]             mem_mem_data,
    input  logic [ADDR_W-1:0]             lookup_addr,
    output logic                          fwd_hit,
    output logic [DATA_W-1:0]             fwd_data,
    output logic [ADDR_W-1:0]             last_store_addr,
    output logic [DATA_W-1:0]             last_store_data,
    output logic [$clog2(SB_DEPTH):0]     sb_count
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;
    localparam int PTR_W = $clog2(SB_DEPTH);

    logic              valid_r;
    logic [DATA_W-1:0] pc_r;
    logic              we_r;
    logic [REG_W-1:0]  write_reg_r;
    logic [DATA_W-1:0] write_data_r;
    logic [OP_W-1:0]   mem_op_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_r;
    logic              store_accept_s;

    // Only a real SW that actually enters the stage is recorded.
    always_comb begin
        store_accept_s = ~stall & ~flush & exe_valid & (exe_mem_op == `MEM_SW_OP);
    end

    // Stage register: rst > flush > stall > capture (bubble when exe_valid is low).
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !exe_valid)) begin
            valid_r      <= 1'b0;
            pc_r         <= {DATA_W{1'b0}};
            we_r         <= 1'b0;
            write_reg_r  <= {REG_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
            mem_op_r     <= `MEM_NOP_OP;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_data_r   <= {DATA_W{1'b0}};
        end else if (!stall) begin
            valid_r      <= 1'b1;
            pc_r         <= exe_pc;
            we_r         <= exe_we;
            write_reg_r  <= exe_write_reg;
            write_data_r <= exe_write_data;
            mem_op_r     <= exe_mem_op;
            mem_addr_r   <= exe_mem_addr;
            mem_data_r   <= exe_mem_data;
        end else begin
            valid_r      <= valid_r;
            pc_r         <= pc_r;
            we_r         <= we_r;
            write_reg_r  <= write_reg_r;
            write_data_r <= write_data_r;
            mem_op_r     <= mem_op_r;
            mem_addr_r   <= mem_addr_r;
            mem_data_r   <= mem_data_r;
        end
    end

    assign mem_valid      = valid_r;
    assign mem_pc         = pc_r;
    assign mem_we         = we_r;
    assign mem_write_reg  = write_reg_r;
    assign mem_write_data = write_data_r;
    assign mem_mem_op     = mem_op_r;
    assign mem_mem_addr   = mem_addr_r;
    assign mem_mem_data   = mem_data_r;

`ifdef EXE_MEM_FWD_EN
    logic [ADDR_W-1:0] sb_addr_r [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_r [SB_DEPTH];
    logic [PTR_W-1:0]  wp_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [PTR_W-1:0]  base_wp_s;
    logic [CNT_W-1:0]  base_cnt_s;
    logic [PTR_W-1:0]  idx_s;
    logic [PTR_W-1:0]  newest_idx_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic              unused_lookup_s;

    // A coincident clear empties the buffer before the store is placed.
    always_comb begin
        if (sb_clear) begin
            base_wp_s  = {PTR_W{1'b0}};
            base_cnt_s = {CNT_W{1'b0}};
        end else begin
            base_wp_s  = wp_r;
            base_cnt_s = cnt_r;
        end
    end

    // Circular store history with saturating occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_r  <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_r[i] <= {ADDR_W{1'b0}};
                sb_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (store_accept_s) begin
            sb_addr_r[base_wp_s] <= exe_mem_addr;
            sb_data_r[base_wp_s] <= exe_mem_data;
            wp_r                 <= base_wp_s + {{(PTR_W-1){1'b0}}, 1'b1};
            if (base_cnt_s == CNT_W'(SB_DEPTH)) begin
                cnt_r <= base_cnt_s;
            end else begin
                cnt_r <= base_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wp_r  <= base_wp_s;
            cnt_r <= base_cnt_s;
        end
    end

    // Walk from oldest to newest valid entry so the newest match is the one kept.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DATA_W{1'b0}};
        idx_s      = {PTR_W{1'b0}};
        for (int k = SB_DEPTH - 1; k >= 0; k--) begin
            idx_s = wp_r - PTR_W'(k) - {{(PTR_W-1){1'b0}}, 1'b1};
            if ((CNT_W'(k) < cnt_r) &&
                (sb_addr_r[idx_s][ADDR_W-1:2] == lookup_addr[ADDR_W-1:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = sb_data_r[idx_s];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    assign newest_idx_s    = wp_r - {{(PTR_W-1){1'b0}}, 1'b1};
    assign fwd_hit         = fwd_hit_s;
    assign fwd_data        = fwd_data_s;
    assign last_store_addr = (cnt_r == {CNT_W{1'b0}}) ? {ADDR_W{1'b0}} : sb_addr_r[newest_idx_s];
    assign last_store_data = (cnt_r == {CNT_W{1'b0}}) ? {DATA_W{1'b0}} : sb_data_r[newest_idx_s];
    assign sb_count        = cnt_r;
    assign unused_lookup_s = ^lookup_addr[1:0];
`else
    logic [ADDR_W-1:0] ls_addr_r;
    logic [DATA_W-1:0] ls_data_r;
    logic              ls_valid_r;
    logic              unused_lookup_s;

    // Single last-store register; store beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_addr_r  <= {ADDR_W{1'b0}};
            ls_data_r  <= {DATA_W{1'b0}};
            ls_valid_r <= 1'b0;
        end else if (store_accept_s) begin
            ls_addr_r  <= exe_mem_addr;
            ls_data_r  <= exe_mem_data;
            ls_valid_r <= 1'b1;
        end else if (sb_clear) begin
            ls_addr_r  <= {ADDR_W{1'b0}};
            ls_data_r  <= {DATA_W{1'b0}};
            ls_valid_r <= 1'b0;
        end else begin
            ls_addr_r  <= ls_addr_r;
            ls_data_r  <= ls_data_r;
            ls_valid_r <= ls_valid_r;
        end
    end

    assign fwd_hit         = 1'b0;
    assign fwd_data        = {DATA_W{1'b0}};
    assign last_store_addr = ls_addr_r;
    assign last_store_data = ls_data_r;
    assign sb_count        = {{(CNT_W-1){1'b0}}, ls_valid_r};
    assign unused_lookup_s = ^lookup_addr;
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage; expectations follow EXE_MEM_FWD_EN when it is defined.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 4'h0
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 4'h2
`endif

module tb_exe_mem_stage;

`ifdef EXE_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, sb_clear, exe_valid, exe_we;
    logic [31:0] exe_pc, exe_write_data, exe_mem_addr, exe_mem_data, lookup_addr;
    logic [4:0]  exe_write_reg;
    logic [3:0]  exe_mem_op;
    logic        mem_valid, mem_we, fwd_hit;
    logic [31:0] mem_pc, mem_write_data, mem_mem_addr, mem_mem_data, fwd_data;
    logic [31:0] last_store_addr, last_store_data;
    logic [4:0]  mem_write_reg;
    logic [3:0]  mem_mem_op;
    logic [2:0]  sb_count;

    int n_vec = 0;
    int n_err = 0;

    exe_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .sb_clear(sb_clear),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_we(exe_we), .exe_write_reg(exe_write_reg),
        .exe_write_data(exe_write_data), .exe_mem_op(exe_mem_op), .exe_mem_addr(exe_mem_addr),
        .exe_mem_data(exe_mem_data), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we),
        .mem_write_reg(mem_write_reg), .mem_write_data(mem_write_data), .mem_mem_op(mem_mem_op),
        .mem_mem_addr(mem_mem_addr), .mem_mem_data(mem_mem_data), .lookup_addr(lookup_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .last_store_addr(last_store_addr),
        .last_store_data(last_store_data), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] a, input logic hit, input logic [31:0] d);
        lookup_addr = a;
        #1;
        chk({tag, "_hit"}, {31'd0, fwd_hit}, {31'd0, hit});
        chk({tag, "_data"}, fwd_data, d);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        exe_valid = 1'b1; exe_mem_op = `MEM_SW_OP; exe_mem_addr = a; exe_mem_data = d;
        exe_pc = 32'h0000_0200; exe_we = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; sb_clear = 1'b0; exe_valid = 1'b0; exe_we = 1'b0;
        exe_pc = 32'd0; exe_write_data = 32'd0; exe_mem_addr = 32'd0; exe_mem_data = 32'd0;
        exe_write_reg = 5'd0; exe_mem_op = `MEM_NOP_OP; lookup_addr = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_op", {28'd0, mem_mem_op}, {28'd0, `MEM_NOP_OP});
        chk("rst_pc", mem_pc, 32'd0);
        chk("rst_cnt", {29'd0, sb_count}, 32'd0);
        chk("rst_lsa", last_store_addr, 32'd0);
        look("rst_look", 32'd0, 1'b0, 32'd0);

        // capture
        exe_valid = 1'b1; exe_pc = 32'h40; exe_we = 1'b1; exe_write_reg = 5'd3;
        exe_write_data = 32'h1234; exe_mem_op = `MEM_NOP_OP;
        tick();
        chk("cap_pc", mem_pc, 32'h40);
        chk("cap_reg", {27'd0, mem_write_reg}, 32'd3);
        chk("cap_wdata", mem_write_data, 32'h1234);
        chk("cap_valid", {31'd0, mem_valid}, 32'd1);
        chk("cap_we", {31'd0, mem_we}, 32'd1);

        // stall holds for two cycles despite new inputs
        stall = 1'b1; exe_pc = 32'h80; exe_write_data = 32'h5555;
        tick(); tick();
        chk("stall_pc", mem_pc, 32'h40);
        chk("stall_wdata", mem_write_data, 32'h1234);

        // flush beats stall
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_op", {28'd0, mem_mem_op}, {28'd0, `MEM_NOP_OP});
        chk("flush_pc", mem_pc, 32'd0);
        chk("flush_we", {31'd0, mem_we}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // capture with exe_valid low loads a bubble
        exe_valid = 1'b1; exe_pc = 32'h44; tick();
        exe_valid = 1'b0; exe_pc = 32'h99; tick();
        chk("bub_valid", {31'd0, mem_valid}, 32'd0);
        chk("bub_pc", mem_pc, 32'd0);

        // store and forward
        sw(32'h100, 32'hAA);
        sw(32'h100, 32'hBB);
        chk("sw_op", {28'd0, mem_mem_op}, {28'd0, `MEM_SW_OP});
        chk("sw_addr", mem_mem_addr, 32'h100);
        chk("sw_mdata", mem_mem_data, 32'hBB);
        look("fwd_102", 32'h102, FWD, FWD ? 32'hBB : 32'd0);
        look("fwd_104", 32'h104, 1'b0, 32'd0);
        chk("fwd_cnt", {29'd0, sb_count}, FWD ? 32'd2 : 32'd1);
        chk("fwd_lsd", last_store_data, 32'hBB);

        // wrap-around
        for (int i = 0; i < 5; i++) sw(32'(4 * i), 32'h500 + 32'(i));
        look("wrap_0", 32'h0, 1'b0, 32'd0);
        look("wrap_10", 32'h10, FWD, FWD ? 32'h504 : 32'd0);
        look("wrap_4", 32'h4, FWD, FWD ? 32'h501 : 32'd0);
        chk("wrap_cnt", {29'd0, sb_count}, FWD ? 32'd4 : 32'd1);
        chk("wrap_lsa", last_store_addr, 32'h10);
        chk("wrap_lsd", last_store_data, 32'h504);

        // stalled, flushed, invalid and non-store ops are not recorded
        stall = 1'b1; sw(32'h200, 32'h77); stall = 1'b0;
        flush = 1'b1; sw(32'h204, 32'h78); flush = 1'b0;
        exe_valid = 1'b0; exe_mem_op = `MEM_SW_OP; exe_mem_addr = 32'h208; tick();
        exe_valid = 1'b1; exe_mem_op = 4'h1; exe_mem_addr = 32'h20C; tick();
        chk("nrec_cnt", {29'd0, sb_count}, FWD ? 32'd4 : 32'd1);
        chk("nrec_lsa", last_store_addr, 32'h10);
        look("nrec_200", 32'h200, 1'b0, 32'd0);

        // clear alone
        exe_valid = 1'b0; exe_mem_op = `MEM_NOP_OP; sb_clear = 1'b1; tick(); sb_clear = 1'b0;
        chk("clr_cnt", {29'd0, sb_count}, 32'd0);
        chk("clr_lsa", last_store_addr, 32'd0);
        look("clr_10", 32'h10, 1'b0, 32'd0);

        // clear coinciding with a store
        sb_clear = 1'b1; sw(32'h20, 32'h33); sb_clear = 1'b0;
        chk("clrsw_cnt", {29'd0, sb_count}, 32'd1);
        chk("clrsw_lsa", last_store_addr, 32'h20);
        look("clrsw_20", 32'h20, FWD, FWD ? 32'h33 : 32'd0);
        sw(32'h24, 32'h34);
        chk("clrsw2_cnt", {29'd0, sb_count}, FWD ? 32'd2 : 32'd1);
        look("clrsw2_20", 32'h20, FWD, FWD ? 32'h33 : 32'd0);

        // reset during stall+flush empties everything
        exe_valid = 1'b1; exe_pc = 32'h60; exe_mem_op = `MEM_NOP_OP; tick();
        rst = 1'b1; stall = 1'b1; flush = 1'b1; tick();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; exe_valid = 1'b0;
        chk("rst2_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst2_pc", mem_pc, 32'd0);
        chk("rst2_cnt", {29'd0, sb_count}, 32'd0);
        chk("rst2_lsd", last_store_data, 32'd0);
        look("rst2_20", 32'h20, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Parametrised EXE→MEM pipeline register for the five-stage CPU, replacing the fixed 32-bit latch with a clocked stage that supports stall, flush and bubble insertion. It also keeps a small circular store-history buffer of the last SB_DEPTH accepted stores. The MEM stage queries this buffer for load-after-store forwarding. It sits between the ALU/EXE stage and the data-memory interface.

## Interface
- DATA_W, 32, data/PC width
- ADDR_W, 32, memory address width
- REG_W, 5, register index width
- OP_W, 4, memory-op code width (codes `MEM_NOP_OP`, `MEM_SW_OP` from defines.v)
- SB_DEPTH, 4, store-history entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- stall  in  1  hold stage contents
- flush  in  1  replace stage contents with a bubble
- sb_clear  in  1  invalidate all store-history entries
- exe_valid  in  1  EXE holds a real instruction
- exe_pc  in  DATA_W  instruction PC
- exe_we  in  1  register write enable
- exe_write_reg  in  REG_W  destination register
- exe_write_data  in  DATA_W  ALU result
- exe_mem_op  in  OP_W  memory op
- exe_mem_addr  in  ADDR_W  memory address
- exe_mem_data  in  DATA_W  store data
- mem_valid, mem_pc, mem_we, mem_write_reg, mem_write_data, mem_mem_op, mem_mem_addr, mem_mem_data  out  (matching widths)  registered stage outputs
- lookup_addr  in  ADDR_W  load address to check
- fwd_hit  out  1  a recorded store matches lookup_addr
- fwd_data  out  DATA_W  data of the newest matching store
- last_store_addr  out  ADDR_W  newest recorded store address
- last_store_data  out  DATA_W  newest recorded store data
- sb_count  out  $clog2(SB_DEPTH)+1  valid entries

## Operation
- Stage register priority at each edge: rst > flush > stall > capture.
- Bubble: mem_valid=0, mem_we=0, mem_mem_op=`MEM_NOP_OP`, and every other output field is 0.
- Capture: if exe_valid=1, copy all exe_* fields; if exe_valid=0, load a bubble.
- Stall: all mem_* outputs hold their values.
- Accepted store: a capture with exe_valid=1 and exe_mem_op=`MEM_SW_OP`.
  - Writes {exe_mem_addr, exe_mem_data} at write pointer wp, then wp increments modulo SB_DEPTH.
  - sb_count saturates at SB_DEPTH. When full, the oldest entry is overwritten.
  - Stalled or flushed stores are never recorded.
- sb_clear: at the edge, sb_count←0 and wp←0.
  - If sb_clear coincides with an accepted store, the clear applies first, then the store is written to entry 0, giving sb_count=1 and wp=1.
  - flush does not affect the buffer.
- Lookup is combinational over valid entries.
  - Compare word-aligned addresses: addr[ADDR_W-1:2].
  - Newest match wins, searching from wp-1 backwards.
  - No match: fwd_hit=0, fwd_data=0.
- last_store_addr and last_store_data show entry wp-1, or 0 when sb_count=0.

## Timing
- Stage latency: 1 cycle. Inputs sampled at edge N appear on mem_* after edge N.
- A store accepted at edge N is visible to the lookup and last_store_* outputs after edge N, in the same cycle it is on mem_*.
- Lookup has zero-cycle latency (combinational from lookup_addr and buffer state).
- Reset values:
  - all mem_* outputs at 0, with mem_mem_op=`MEM_NOP_OP`
  - sb_count=0, wp=0
  - fwd_hit=0, fwd_data=0
  - last_store_addr=0, last_store_data=0
- Reset mid-stall or mid-flush: reset wins, and the buffer is emptied.

## Configuration
- EXE_MEM_FWD_EN defined: full SB_DEPTH store-history buffer and lookup, as described above.
- EXE_MEM_FWD_EN undefined:
  - the buffer reduces to a single last-store register with the same update, clear and reset rules
  - sb_count is 0 or 1
  - fwd_hit and fwd_data are tied to 0, and lookup_addr is ignored
  - the stage register is unchanged

## Test plan
- Reset then capture: drive exe_valid=1, exe_pc=0x40, exe_we=1, exe_write_reg=3, exe_write_data=0x1234 for 1 cycle → after the next edge, mem_pc=0x40, mem_write_reg=3, mem_write_data=0x1234, mem_valid=1.
- Stall and flush: with stage holding pc=0x40, assert stall 2 cycles → outputs hold 0x40; assert stall and flush together → bubble (mem_valid=0, mem_mem_op=`MEM_NOP_OP`, mem_pc=0).
- Store and forward: accept SW addr=0x100 data=0xAA, then SW addr=0x100 data=0xBB → lookup 0x102 gives fwd_hit=1, fwd_data=0xBB; lookup 0x104 gives fwd_hit=0; sb_count=2.
- Wrap-around: accept 5 stores to addresses 0x0, 0x4, 0x8, 0xC, 0x10 with SB_DEPTH=4 → lookup 0x0 misses, lookup 0x10 hits; sb_count=4; last_store_addr=0x10.
- Stalled store not recorded, clear with store: SW presented with stall=1 → sb_count unchanged; sb_clear together with an accepted SW addr=0x20 → sb_count=1, last_store_addr=0x20.
- Macro off: build without EXE_MEM_FWD_EN and repeat the store-and-forward case → fwd_hit=0, last_store_data=0xBB, sb_count=1.
